// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory request/hit pair plus the decode-side
// valid/ready, redirect and halt signals.
interface fetch_unit_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;

  modport master (
    output iREN, iaddr, ins, ins_pc, ins_valid, halted,
    input  ihit, iload, ins_ready, redirect, redirect_pc, halt
  );

  modport slave (
    input  iREN, iaddr, ins, ins_pc, ins_valid, halted,
    output ihit, iload, ins_ready, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, requests words from instruction
// memory and queues {instruction, pc} pairs for the decode stage.
module fetch_unit #(
  parameter logic [31:0] PC_INIT   = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input logic          CLK,
  input logic          RST,
  fetch_unit_if.master bus
);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PW:0] DEPTH = (PW+1)'(BUF_DEPTH);
  localparam logic [0:0] FETCH  = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  logic [0:0]                  state;
  logic [31:0]                 pc;
  logic [PW-1:0]               wptr, rptr;
  logic [PW:0]                 cnt;
  logic [BUF_DEPTH-1:0][31:0]  buf_ins, buf_pc;
  logic                        in_fetch, halt_take, push, pop;

  assign in_fetch      = (state == FETCH);
  assign bus.ins_valid = in_fetch && (cnt != '0);
  // halt only counts when there is a head instruction it refers to
  assign halt_take     = in_fetch && bus.halt && bus.ins_valid;
  assign bus.iREN      = in_fetch && !RST && (cnt < DEPTH) && !bus.redirect && !halt_take;
  assign bus.iaddr     = pc;
  assign bus.halted    = (state == HALTED);
  assign push          = bus.iREN && bus.ihit;
  assign pop           = bus.ins_valid && bus.ins_ready && !bus.halt && !bus.redirect;

  assign bus.ins    = bus.ins_valid ? buf_ins[rptr] : 32'h0;
  assign bus.ins_pc = bus.ins_valid ? buf_pc[rptr]  : 32'h0;

  // storage needs no reset: it is only visible while ins_valid is set
  always_ff @(posedge CLK) begin
    if (push) begin
      buf_ins[wptr] <= bus.iload;
      buf_pc[wptr]  <= pc;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FETCH;
      pc    <= PC_INIT;
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
    end else if (in_fetch) begin
      if (halt_take) begin
        state <= HALTED;
        wptr  <= '0;
        rptr  <= '0;
        cnt   <= '0;
      end else if (bus.redirect) begin
        pc    <= {bus.redirect_pc[31:2], 2'b00};
        wptr  <= '0;
        rptr  <= '0;
        cnt   <= '0;
      end else begin
        if (push) begin
          wptr <= wptr + 1'b1;
          pc   <= pc + 32'd4;
        end
        if (pop) rptr <= rptr + 1'b1;
        if (push && !pop)      cnt <= cnt + 1'b1;
        else if (pop && !push) cnt <= cnt - 1'b1;
      end
    end
  end
endmodule
